// File: rtl/seq_chk_pkg.sv
// Shared constants and the verdict type for the sequence-implication checker.
package seq_chk_pkg;

    localparam int unsigned S1_LEN   = 2;  // a[*2] after the rise
    localparam int unsigned S2_LEN   = 3;  // b[*3]
    localparam int unsigned IMPL_LAT = 3;  // rise sample to |-> verdict, in edges
    localparam int unsigned IMP_LAT  = 2;  // rise sample to implies verdict, in edges

    typedef enum logic [1:0] {
        NONE,
        PASS,
        FAIL,
        VAC
    } verdict_e;

endpackage

// File: rtl/seq_chk_sat_cnt.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module seq_chk_sat_cnt #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // Count verdicts, holding at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/seq_implies_checker.sv
// Hardware evaluation of ($rose(a) ##0 a[*2]) against b[*3] under both |-> and implies.
// Optional feature macro: SEQ_CHK_VACUOUS_EN adds the vacuous-attempt counters.
module seq_implies_checker
    import seq_chk_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             a,
    input  logic             b,
    output logic             impl_pass,
    output logic             impl_fail,
    output logic             imp_pass,
    output logic             imp_fail,
    output logic [CNT_W-1:0] impl_pass_cnt,
    output logic [CNT_W-1:0] impl_fail_cnt,
    output logic [CNT_W-1:0] imp_pass_cnt,
    output logic [CNT_W-1:0] imp_fail_cnt
`ifdef SEQ_CHK_VACUOUS_EN
    ,
    output logic [CNT_W-1:0] impl_vac_cnt,
    output logic [CNT_W-1:0] imp_vac_cnt
`endif
);

    // The live sample plus these registered stages form the 4-deep window E0..E3.
    // a_hist[0] is a at the previous edge, a_hist[1] two edges back; same for b_hist.
    // start_hist[k] marks an attempt that started k+1 edges ago.
    logic [S1_LEN-1:0]   a_hist;
    logic [S2_LEN-2:0]   b_hist;
    logic [IMPL_LAT-1:0] start_hist;

    logic     start;
    logic     b_all;
    verdict_e impl_verdict;
    verdict_e imp_verdict;

    // Rising a needs a 0 at the previous edge; history resets to 0 so the
    // first edge after reset can start an attempt.
    assign start = en & a & ~a_hist[0];

    // Both window checks end on the current edge and span the last three b samples.
    assign b_all = &{b_hist, b};

    // Shift the sampled a/b history and the per-slot start markers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_hist     <= '0;
            b_hist     <= '0;
            start_hist <= '0;
        end else begin
            a_hist     <= {a_hist[S1_LEN-2:0], a};
            b_hist     <= {b_hist[S2_LEN-3:0], b};
            start_hist <= {start_hist[IMPL_LAT-2:0], start};
        end
    end

    // Decide this edge's verdict for each semantics from the slot ages.
    always_comb begin
        impl_verdict = NONE;
        imp_verdict  = NONE;

        // |->: s1 fails at E1 -> vacuous; otherwise b[*3] over E1..E3 decides at E3.
        // A vacuous E1 and a live E3 cannot coincide: a new rise at E2 needs a=0 at E1.
        if (start_hist[0] && !a) begin
            impl_verdict = VAC;
        end else if (start_hist[IMPL_LAT-1] && a_hist[S1_LEN-1]) begin
            impl_verdict = b_all ? PASS : FAIL;
        end

        // implies: b over E0..E2, resolved at E2 together with the s1 outcome.
        if (start_hist[IMP_LAT-1]) begin
            if (!a_hist[0]) begin
                imp_verdict = VAC;
            end else begin
                imp_verdict = b_all ? PASS : FAIL;
            end
        end
    end

    // Register the one-cycle verdict pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            impl_pass <= 1'b0;
            impl_fail <= 1'b0;
            imp_pass  <= 1'b0;
            imp_fail  <= 1'b0;
        end else begin
            impl_pass <= (impl_verdict == PASS);
            impl_fail <= (impl_verdict == FAIL);
            imp_pass  <= (imp_verdict == PASS);
            imp_fail  <= (imp_verdict == FAIL);
        end
    end

    seq_chk_sat_cnt #(.W(CNT_W)) u_impl_pass_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (impl_verdict == PASS),
        .cnt (impl_pass_cnt)
    );

    seq_chk_sat_cnt #(.W(CNT_W)) u_impl_fail_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (impl_verdict == FAIL),
        .cnt (impl_fail_cnt)
    );

    seq_chk_sat_cnt #(.W(CNT_W)) u_imp_pass_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (imp_verdict == PASS),
        .cnt (imp_pass_cnt)
    );

    seq_chk_sat_cnt #(.W(CNT_W)) u_imp_fail_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (imp_verdict == FAIL),
        .cnt (imp_fail_cnt)
    );

`ifdef SEQ_CHK_VACUOUS_EN
    seq_chk_sat_cnt #(.W(CNT_W)) u_impl_vac_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (impl_verdict == VAC),
        .cnt (impl_vac_cnt)
    );

    seq_chk_sat_cnt #(.W(CNT_W)) u_imp_vac_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (imp_verdict == VAC),
        .cnt (imp_vac_cnt)
    );
`endif

endmodule
